mem_access_unit: RTL

- Executes the load/store memory phase (P4/P5) for the 16-bit multi-phase controller.
- Accepts one request per instruction: opcode class, base register value, 8-bit displacement, store data and destination register index.
- Computes the effective address and drives the single-port synchronous instruction/data memory.
- Returns either load data for register-file writeback or store completion, using a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ea_calc.sv | 20 ++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit multi-phase controller.
// Holds instruction class codes, the memory-phase FSM states and the EA sign-extension helper.
package cpu_pkg;

  localparam int unsigned DataW   = 16;
  localparam int unsigned RegIdxW = 3;
  localparam int unsigned DispW   = 8;

  typedef enum logic [1:0] {
    ClsLoad  = 2'b00,
    ClsStore = 2'b01,
    ClsLiBr  = 2'b10,
    ClsCalc  = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } mau_state_e;

  function automatic logic [DataW-1:0] sext_disp(input logic [DispW-1:0] disp);
    return {{(DataW - DispW){disp[DispW-1]}}, disp};
  endfunction

endpackage

// File: rtl/ea_calc.sv
// Effective-address adder: base + sign-extended 8-bit displacement, modulo 2^16.
// Flags any address outside the implemented 2^MemAw-word memory.
module ea_calc
  import cpu_pkg::*;
#(
  parameter int unsigned MemAw = 8
) (
  input  logic [DataW-1:0] base_i,
  input  logic [DispW-1:0] disp_i,
  output logic [DataW-1:0] ea_o,
  output logic             fault_o
);

  always_comb begin
    ea_o    = base_i + sext_disp(disp_i);
    // A shift of MemAw >= 16 leaves zero, so a full-width memory never faults.
    fault_o = (ea_o >> MemAw) != '0;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store memory phase: registers the effective address on accept, drives the synchronous
// memory and returns load data or store completion through a valid/ready response.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [DataW-1:0]   req_base,
  input  logic [DispW-1:0]   req_disp,
  input  logic [DataW-1:0]   req_wdata,
  input  logic [RegIdxW-1:0] req_rd,
  output logic [DataW-1:0]   mem_address,
  output logic [DataW-1:0]   mem_data,
  output logic               mem_wren,
  input  logic [DataW-1:0]   mem_q,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_wb,
  output logic [RegIdxW-1:0] resp_rd,
  output logic [DataW-1:0]   resp_data,
  output logic               resp_fault
);

  mau_state_e         state_q;
  instr_class_e       cls_q;
  logic [RegIdxW-1:0] rd_q;
  logic [1:0]         cnt_q;
  logic [DataW-1:0]   mem_address_q;
  logic [DataW-1:0]   mem_data_q;
  logic               mem_wren_q;
  logic               resp_valid_q;
  logic               resp_wb_q;
  logic [RegIdxW-1:0] resp_rd_q;
  logic [DataW-1:0]   resp_data_q;
  logic               resp_fault_q;

  logic [DataW-1:0]   ea;
  logic               ea_fault;

  ea_calc #(
    .MemAw (MEM_AW)
  ) u_ea_calc (
    .base_i  (req_base),
    .disp_i  (req_disp),
    .ea_o    (ea),
    .fault_o (ea_fault)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cls_q         <= ClsLoad;
      rd_q          <= '0;
      cnt_q         <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_wb_q     <= 1'b0;
      resp_rd_q     <= '0;
      resp_data_q   <= '0;
      resp_fault_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cls_q <= req_store ? ClsStore : ClsLoad;
            rd_q  <= req_rd;
            if (ea_fault) begin
              // No memory access at all: report the fault straight away.
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_wb_q    <= 1'b0;
              resp_rd_q    <= req_rd;
              resp_data_q  <= '0;
            end else begin
              state_q       <= StIssue;
              mem_address_q <= ea;
              mem_data_q    <= req_store ? req_wdata : '0;
              mem_wren_q    <= req_store;
            end
          end
        end
        StIssue: begin
          mem_wren_q <= 1'b0;
          if (cls_q == ClsStore) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_wb_q    <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= rd_q;
          end else begin
            state_q <= StWait;
            cnt_q   <= 2'(RD_LAT - 1);
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_wb_q    <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= rd_q;
            resp_data_q  <= mem_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_wb_q    <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign resp_valid  = resp_valid_q;
  assign resp_wb     = resp_wb_q;
  assign resp_rd     = resp_rd_q;
  assign resp_data   = resp_data_q;
  assign resp_fault  = resp_fault_q;

endmodule
